// File: rtl/fp_pkg.sv
// Shared types for the single-precision adder and its sharing controller.
package fp_pkg;

  typedef logic [31:0] fp32_t;

  localparam int FADD_LAT = 3;
  localparam int TAG_ID_W = 3;  // wide enough for up to 8 requesters

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } fadd_tag_t;

  function automatic fp32_t fp_neg(input fp32_t x);
    return {~x[31], x[30:0]};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a registered
// pointer, which moves just past the winner on every grant.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             hold,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id
);

  localparam int SW = ID_W + 1;

  logic [ID_W-1:0] r_ptr;
  logic [SW-1:0]   w_sum;
  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_comb begin
    // NOTE: every variable gets a default before the search loop so no latch is inferred.
    grant    = '0;
    grant_id = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + SW'(k);
      if (w_sum >= SW'(N_REQ)) w_sum = w_sum - SW'(N_REQ);
      w_idx = w_sum[ID_W-1:0];
      if (rst_n && !hold && !w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_id     = w_idx;
        w_found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (|grant) begin
      r_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/fadd_share_ctrl.sv
// Shares one pipelined FP adder among N_REQ requesters; a tag pipeline matched
// to the adder latency returns each result with its owner's ID.
module fadd_share_ctrl
  import fp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT   = FADD_LAT,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hold,
  input  logic  [N_REQ-1:0]      req_valid,
  input  fp32_t [N_REQ-1:0]      req_a,
  input  fp32_t [N_REQ-1:0]      req_b,
  input  logic  [N_REQ-1:0]      req_sub,
  output logic  [N_REQ-1:0]      req_ready,
  output fp32_t                  fadd_a,
  output fp32_t                  fadd_b,
  input  fp32_t                  fadd_c,
  output logic                   resp_valid,
  output logic  [ID_W-1:0]       resp_id,
  output fp32_t                  resp_c,
  output logic  [2:0]            inflight,
  output logic                   busy
);

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_grant_id;
  logic             w_hs;

  fp32_t            r_fadd_a;
  fp32_t            r_fadd_b;
  fadd_tag_t        r_tag [LAT+1];
  logic [2:0]       r_inflight;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .hold     (hold),
    .grant    (w_grant),
    .grant_id (w_grant_id)
  );

  // A grant is only ever given to a valid requester, so any grant is a handshake.
  assign w_hs = |w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fadd_a <= '0;
      r_fadd_b <= '0;
    end else if (w_hs) begin
      r_fadd_a <= req_a[w_grant_id];
      r_fadd_b <= req_sub[w_grant_id] ? fp_neg(req_b[w_grant_id]) : req_b[w_grant_id];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tag stages are reset so work in flight at reset never produces a response.
      for (int k = 0; k <= LAT; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_hs, id: TAG_ID_W'(w_grant_id)};
      for (int k = 1; k <= LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_hs, resp_valid})
        2'b10:   r_inflight <= r_inflight + 3'd1;
        2'b01:   r_inflight <= r_inflight - 3'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign req_ready  = w_grant;
  assign fadd_a     = r_fadd_a;
  assign fadd_b     = r_fadd_b;
  assign resp_valid = r_tag[LAT].valid;
  assign resp_id    = ID_W'(r_tag[LAT].id);
  assign resp_c     = fadd_c;
  assign inflight   = r_inflight;
  assign busy       = (r_inflight != 3'd0);

endmodule

// File: tb/tb_fadd_share_ctrl.sv
// Directed bench for fadd_share_ctrl with a 3-stage behavioural adder stand-in.
module tb_fadd_share_ctrl;
  import fp_pkg::*;

  localparam int N  = 4;
  localparam int L  = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            hold;
  logic  [N-1:0]   req_valid;
  fp32_t [N-1:0]   req_a;
  fp32_t [N-1:0]   req_b;
  logic  [N-1:0]   req_sub;
  logic  [N-1:0]   req_ready;
  fp32_t           fadd_a;
  fp32_t           fadd_b;
  fp32_t           fadd_c;
  logic            resp_valid;
  logic  [IW-1:0]  resp_id;
  fp32_t           resp_c;
  logic  [2:0]     inflight;
  logic            busy;

  int errors = 0;
  int checks = 0;

  fp32_t m_s1, m_s2, m_c;

  fadd_share_ctrl #(.N_REQ(N), .LAT(L), .ID_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (hold),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .req_ready  (req_ready),
    .fadd_a     (fadd_a),
    .fadd_b     (fadd_b),
    .fadd_c     (fadd_c),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_c     (resp_c),
    .inflight   (inflight),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Adder stand-in: known IEEE vectors from a table, anything else a^b.
  function automatic fp32_t model_add(input fp32_t a, input fp32_t b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;
      64'h40400000_BF800000: return 32'h40000000;
      64'h7F800000_FF800000: return 32'h7FC00000;
      default:               return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    m_s1 <= model_add(fadd_a, fadd_b);
    m_s2 <= m_s1;
    m_c  <= m_s2;
  end
  assign fadd_c = m_c;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    hold      = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    #12;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_resp_id: got %0d expected 0", resp_id); end
    checks++; if (inflight !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_inflight: got %0d/%b expected 0/0", inflight, busy); end
    checks++; if (fadd_a !== 32'h0 || fadd_b !== 32'h0) begin errors++; $display("FAIL reset_operands: got %h/%h expected 0/0", fadd_a, fadd_b); end
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One isolated request from requester idx; checks grant, operands and response timing.
  task automatic issue_one(input string nm, input logic [IW-1:0] idx, input fp32_t a, input fp32_t b,
                           input logic sub, input fp32_t exp_b, input fp32_t exp_c);
    logic [N-1:0] exp_rdy;
    exp_rdy      = '0;
    exp_rdy[idx] = 1'b1;
    req_a[idx]   = a;
    req_b[idx]   = b;
    req_sub[idx] = sub;
    req_valid    = exp_rdy;
    @(negedge clk);
    checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL %s_ready: got %b expected %b", nm, req_ready, exp_rdy); end
    next_cycle();
    req_valid = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if (fadd_a !== a || fadd_b !== exp_b) begin errors++; $display("FAIL %s_operands: got %h/%h expected %h/%h", nm, fadd_a, fadd_b, a, exp_b); end
        checks++; if (inflight !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL %s_inflight1: got %0d/%b expected 1/1", nm, inflight, busy); end
      end
      checks++; if (resp_valid !== (c == 4)) begin errors++; $display("FAIL %s_resp_valid_c%0d: got %b expected %b", nm, c, resp_valid, (c == 4)); end
      if (c == 4) begin
        checks++; if (resp_id !== idx || resp_c !== exp_c) begin errors++; $display("FAIL %s_resp: got id %0d c %h expected id %0d c %h", nm, resp_id, resp_c, idx, exp_c); end
      end
      if (c == 5) begin
        checks++; if (inflight !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL %s_drain: got %0d/%b expected 0/0", nm, inflight, busy); end
      end
      next_cycle();
    end
  endtask

  task automatic test_single_add();
    issue_one("add", 2'd0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000);
  endtask

  task automatic test_subtract();
    issue_one("sub", 2'd2, 32'h40400000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h40000000);
  endtask

  task automatic test_special_values();
    issue_one("inf", 2'd3, 32'h7F800000, 32'h7F800000, 1'b1, 32'hFF800000, 32'h7FC00000);
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_rdy;
    logic [2:0]   exp_inf;
    logic [2:0]   peak;
    int           r;
    peak = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i]   = 32'hA0000000 | 32'(i);
      req_b[i]   = 32'h00000050;
      req_sub[i] = 1'b0;
    end
    for (int t = 0; t <= 12; t++) begin
      req_valid = (t < 8) ? '1 : '0;
      exp_rdy   = '0;
      if (t < 8) exp_rdy[IW'(t % 4)] = 1'b1;
      exp_inf   = (t <= 4) ? 3'(t) : ((t <= 8) ? 3'd4 : 3'(12 - t));
      @(negedge clk);
      if (inflight > peak) peak = inflight;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL fair_ready_t%0d: got %b expected %b", t, req_ready, exp_rdy); end
      checks++; if (inflight !== exp_inf) begin errors++; $display("FAIL fair_inflight_t%0d: got %0d expected %0d", t, inflight, exp_inf); end
      checks++; if (resp_valid !== (t >= 4 && t < 12)) begin errors++; $display("FAIL fair_resp_valid_t%0d: got %b expected %b", t, resp_valid, (t >= 4 && t < 12)); end
      if (t >= 4 && t < 12) begin
        r = (t - 4) % 4;
        checks++; if (resp_id !== IW'(r) || resp_c !== 32'hA0000050 + 32'(r)) begin errors++; $display("FAIL fair_resp_t%0d: got id %0d c %h expected id %0d c %h", t, resp_id, resp_c, r, 32'hA0000050 + 32'(r)); end
      end
      next_cycle();
    end
    checks++; if (peak !== 3'd4) begin errors++; $display("FAIL fair_peak: got %0d expected 4", peak); end
  endtask

  task automatic test_hold();
    req_a[0] = 32'h3F800000; req_b[0] = 32'h40000000; req_sub[0] = 1'b0;
    req_a[1] = 32'h00001234; req_b[1] = 32'h00000001; req_sub[1] = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL hold_pre_ready: got %b expected 0001", req_ready); end
    next_cycle();
    req_valid = '0;
    next_cycle();
    for (int c = 2; c <= 4; c++) begin
      hold      = 1'b1;
      req_valid = 4'b0010;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hold_ready_c%0d: got %b expected 0000", c, req_ready); end
      checks++; if (resp_valid !== (c == 4)) begin errors++; $display("FAIL hold_resp_valid_c%0d: got %b expected %b", c, resp_valid, (c == 4)); end
      if (c == 4) begin
        checks++; if (resp_id !== 2'd0 || resp_c !== 32'h40400000) begin errors++; $display("FAIL hold_resp: got id %0d c %h expected id 0 c 40400000", resp_id, resp_c); end
      end
      next_cycle();
    end
    hold = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_release_ready: got %b expected 0010", req_ready); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL hold_release_inflight: got %0d expected 0", inflight); end
    next_cycle();
    req_valid = '0;
    for (int c = 6; c <= 9; c++) begin
      @(negedge clk);
      checks++; if (resp_valid !== (c == 9)) begin errors++; $display("FAIL hold_r1_valid_c%0d: got %b expected %b", c, resp_valid, (c == 9)); end
      if (c == 9) begin
        checks++; if (resp_id !== 2'd1 || resp_c !== 32'h00001235) begin errors++; $display("FAIL hold_r1_resp: got id %0d c %h expected id 1 c 00001235", resp_id, resp_c); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midflight();
    logic [N-1:0] exp_rdy [3];
    exp_rdy[0] = 4'b0100;
    exp_rdy[1] = 4'b1000;
    exp_rdy[2] = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      req_valid = '1;
      @(negedge clk);
      checks++; if (req_ready !== exp_rdy[c]) begin errors++; $display("FAIL rst_pre_ready_c%0d: got %b expected %b", c, req_ready, exp_rdy[c]); end
      next_cycle();
    end
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    checks++; if (inflight !== 3'd0 || busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got %0d/%b/%b expected 0/0/0", inflight, busy, resp_valid); end
    next_cycle();
    rst_n     = 1'b1;
    req_valid = 4'b0011;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b expected 0001", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_stale_c0: got %b expected 0", resp_valid); end
    next_cycle();
    req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL rst_post_inflight: got %0d expected 1", inflight); end
      end
      checks++; if (resp_valid !== (c == 4)) begin errors++; $display("FAIL rst_resp_valid_c%0d: got %b expected %b", c, resp_valid, (c == 4)); end
      if (c == 4) begin
        checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL rst_resp_id: got %0d expected 0", resp_id); end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_subtract();
    test_special_values();
    test_fairness();
    test_hold();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
